// File: rtl/prim_secded_inv_39_32_pkg.sv
// Shared constants, types and decode helpers for the inverted Hsiao SECDED(39,32) code.
package prim_secded_inv_39_32_pkg;

    localparam logic [38:0] InvMask = 39'h2A00000000;

    localparam logic [38:0] HMask [7] = '{
        39'h002606bd25, 39'h00deba8050, 39'h00413d89aa, 39'h0031234ed1,
        39'h00c2c1323b, 39'h002dcc624c, 39'h0098505586
    };

    typedef enum logic [1:0] {
        SecdedOk     = 2'b00,
        SecdedSingle = 2'b01,
        SecdedDouble = 2'b10
    } secded_err_e;

    // w is the codeword with the check-bit inversion already removed.
    function automatic logic [6:0] secded_syndrome(input logic [38:0] w);
        logic [6:0] syn;
        for (int k = 0; k < 7; k++) begin
            syn[k] = ^(w & (HMask[k] | (39'd1 << (32 + k))));
        end
        return syn;
    endfunction

    function automatic logic [31:0] secded_correct(input logic [31:0] data,
                                                   input logic [6:0]  syn);
        logic [31:0] fixed;
        logic [6:0]  col;
        fixed = data;
        for (int j = 0; j < 32; j++) begin
            for (int k = 0; k < 7; k++) begin
                col[k] = HMask[k][j];
            end
            if (col == syn) begin
                fixed[j] = ~data[j];
            end
        end
        return fixed;
    endfunction

    function automatic secded_err_e secded_classify(input logic [6:0] syn);
        secded_err_e err;
        if (syn == 7'd0) begin
            err = SecdedOk;
        end else if (^syn) begin
            err = SecdedSingle;
        end else begin
            err = SecdedDouble;
        end
        return err;
    endfunction

endpackage

// File: rtl/prim_sat_cnt.sv
// Saturating event counter with a clear that takes priority over increment.
module prim_sat_cnt #(
    parameter int CntW = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clr_i,
    input  logic            inc_i,
    output logic [CntW-1:0] cnt_o
);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {CntW{1'b1}})) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/prim_secded_inv_39_32_dec_pipe.sv
// Two-stage valid/ready SECDED(39,32) decoder with saturating error counters.
// Optional error log enabled by defining PRIM_SECDED_ERR_LOG_EN.
module prim_secded_inv_39_32_dec_pipe
    import prim_secded_inv_39_32_pkg::*;
#(
    parameter int CntW = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [38:0]     in_data_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [31:0]     out_data_o,
    output logic [6:0]      out_syndrome_o,
    output logic [1:0]      out_err_o,
    input  logic            cnt_clr_i,
    output logic [CntW-1:0] cnt_single_o,
    output logic [CntW-1:0] cnt_double_o
`ifdef PRIM_SECDED_ERR_LOG_EN
    ,
    output logic            log_valid_o,
    output logic [6:0]      log_syndrome_o,
    output logic [38:0]     log_data_o
`endif
);

    logic [38:0] w;
    logic        s1_ready, s2_ready, out_fire;

    logic        s1_valid_q, s1_valid_d;
    logic [31:0] s1_data_q, s1_data_d;
    logic [6:0]  s1_syn_q, s1_syn_d;

    logic        s2_valid_q, s2_valid_d;
    logic [31:0] s2_data_q, s2_data_d;
    logic [6:0]  s2_syn_q, s2_syn_d;
    logic [1:0]  s2_err_q, s2_err_d;

    // A stage accepts new contents when empty or when its word leaves this cycle.
    always_comb begin
        w          = in_data_i ^ InvMask;
        s2_ready   = ~s2_valid_q | out_ready_i;
        s1_ready   = ~s1_valid_q | s2_ready;
        out_fire   = s2_valid_q & out_ready_i;

        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_syn_d   = s1_syn_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_syn_d   = s2_syn_q;
        s2_err_d   = s2_err_q;

        if (s1_ready) begin
            s1_valid_d = in_valid_i;
            if (in_valid_i) begin
                s1_data_d = w[31:0];
                s1_syn_d  = secded_syndrome(w);
            end
        end

        if (s2_ready) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = secded_correct(s1_data_q, s1_syn_q);
                s2_syn_d  = s1_syn_q;
                s2_err_d  = secded_classify(s1_syn_q);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_syn_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_syn_q   <= '0;
            s2_err_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_syn_q   <= s1_syn_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_syn_q   <= s2_syn_d;
            s2_err_q   <= s2_err_d;
        end
    end

    assign in_ready_o     = s1_ready;
    assign out_valid_o    = s2_valid_q;
    assign out_data_o     = s2_data_q;
    assign out_syndrome_o = s2_syn_q;
    assign out_err_o      = s2_err_q;

    prim_sat_cnt #(.CntW(CntW)) u_cnt_single (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (cnt_clr_i),
        .inc_i (out_fire & s2_err_q[0]),
        .cnt_o (cnt_single_o)
    );

    prim_sat_cnt #(.CntW(CntW)) u_cnt_double (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (cnt_clr_i),
        .inc_i (out_fire & s2_err_q[1]),
        .cnt_o (cnt_double_o)
    );

`ifdef PRIM_SECDED_ERR_LOG_EN
    // The raw codeword travels alongside the data so the log can record it untouched.
    logic [38:0] s1_raw_q, s1_raw_d;
    logic [38:0] s2_raw_q, s2_raw_d;
    logic        log_valid_q, log_valid_d;
    logic [6:0]  log_syn_q, log_syn_d;
    logic [38:0] log_data_q, log_data_d;

    always_comb begin
        s1_raw_d    = s1_raw_q;
        s2_raw_d    = s2_raw_q;
        log_valid_d = log_valid_q;
        log_syn_d   = log_syn_q;
        log_data_d  = log_data_q;

        if (s1_ready && in_valid_i) begin
            s1_raw_d = in_data_i;
        end
        if (s2_ready && s1_valid_q) begin
            s2_raw_d = s1_raw_q;
        end

        if (cnt_clr_i) begin
            log_valid_d = 1'b0;
            log_syn_d   = '0;
            log_data_d  = '0;
        end else if (out_fire && (s2_syn_q != 7'd0) && !log_valid_q) begin
            log_valid_d = 1'b1;
            log_syn_d   = s2_syn_q;
            log_data_d  = s2_raw_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_raw_q    <= '0;
            s2_raw_q    <= '0;
            log_valid_q <= 1'b0;
            log_syn_q   <= '0;
            log_data_q  <= '0;
        end else begin
            s1_raw_q    <= s1_raw_d;
            s2_raw_q    <= s2_raw_d;
            log_valid_q <= log_valid_d;
            log_syn_q   <= log_syn_d;
            log_data_q  <= log_data_d;
        end
    end

    assign log_valid_o    = log_valid_q;
    assign log_syndrome_o = log_syn_q;
    assign log_data_o     = log_data_q;
`endif

endmodule
